// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory handshake, the downstream instruction handshake,
// the redirect inputs from control/ALU and the status outputs of instr_fetch.
//   master : the fetch stage (drives imem_req/imem_addr, inst_* fields, status)
//   slave  : memory + downstream stage (drives ack/rdata, inst_ready, redirects)
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic        br_cond;
    logic [31:0] rs_data;
    logic        fault;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, opcode, funct, pc,
               link_addr, fault, retired,
        input  imem_ack, imem_rdata, inst_ready, Branch, Jump, JumpReg,
               br_cond, rs_data
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, opcode, funct, pc,
               link_addr, fault, retired,
        output imem_ack, imem_rdata, inst_ready, Branch, Jump, JumpReg,
               br_cond, rs_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Mini-MIPS instruction fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents it downstream until retired, then redirects the PC from the
// JumpReg/Jump/Branch controls. A misaligned target parks the block in FAULT
// until reset.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  instr_fetch_if.master (memory, downstream, redirect and status signals)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state;
    logic              req_q;
    logic              valid_q;
    logic              fault_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   inst_q;
    logic [XLEN-1:0]   retired_q;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   br_off;
    logic [XLEN-1:0]   jmp_target;
    logic [XLEN-1:0]   next_pc;

    // Redirect target; inputs only matter on the retire cycle.
    always_comb begin
        pc_plus4   = pc_q + XLEN'(4);
        br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        jmp_target = {pc_plus4[31:28], inst_q[25:0], 2'b00};
        next_pc    = pc_plus4;
        if (bus.JumpReg) begin
            next_pc = bus.rs_data;
        end else if (bus.Jump) begin
            next_pc = jmp_target;
        end else if (bus.Branch && bus.br_cond) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    // Fetch/hold/fault sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        inst_q  <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.inst_ready) begin
                        valid_q <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            pc_q      <= next_pc;
                            retired_q <= retired_q + XLEN'(1);
                            req_q     <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                    state   <= FAULT;
                end
            endcase
        end
    end

    // Request is masked by rst so memory never sees a request in a reset cycle.
    assign bus.imem_req   = req_q & ~rst;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.opcode     = inst_q[31:26];
    assign bus.funct      = inst_q[5:0];
    assign bus.pc         = pc_q;
    assign bus.link_addr  = pc_plus4;
    assign bus.fault      = fault_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run, all checked against a PC/retire model built from the redirect rules.
module tb_instr_fetch;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ret;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Redirect inputs are don't-care outside the retire cycle.
    task automatic rand_ctl();
        bus.Branch  = 1'($urandom);
        bus.Jump    = 1'($urandom);
        bus.JumpReg = 1'($urandom);
        bus.br_cond = 1'($urandom);
        bus.rs_data = $urandom;
    endtask

    // Model: next PC from the priority rules with plain 32-bit arithmetic.
    function automatic logic [31:0] model_next(input bit jr, input bit j, input bit br,
                                               input bit cond, input logic [31:0] rs);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = m_pc + 32'd4;
        off = 32'($signed(m_inst[15:0]));
        if (jr)              return rs;
        else if (j)          return (p4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) * 32'd4);
        else if (br && cond) return p4 + off * 32'd4;
        else                 return p4;
    endfunction

    // Called at a negedge; ends at a negedge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'($urandom);
        bus.imem_rdata = $urandom;
        #1 chk("req_in_rst", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc = 32'h0; m_inst = 32'h0; m_ret = 32'h0;
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd1);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
    endtask

    // FETCH with 'waits' wait states; leaves the instruction presented.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i <= waits; i++) begin
            bus.imem_ack   = (i == waits);
            bus.imem_rdata = (i == waits) ? word : $urandom;
            bus.inst_ready = 1'($urandom);
            rand_ctl();
            #1;
            chk("f_req", 32'(bus.imem_req), 32'd1);
            chk("f_addr", bus.imem_addr, m_pc);
            chk("f_valid", 32'(bus.inst_valid), 32'd0);
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        m_inst = word;
        #1;
        chk("h_valid", 32'(bus.inst_valid), 32'd1);
        chk("h_inst", bus.inst, word);
        chk("h_opcode", 32'(bus.opcode), 32'(word[31:26]));
        chk("h_funct", 32'(bus.funct), 32'(word[5:0]));
        chk("h_pc", bus.pc, m_pc);
        chk("h_link", bus.link_addr, m_pc + 32'd4);
    endtask

    // HOLD for 'stall' cycles, then retire with the given redirect controls.
    task automatic do_hold(input int stall, input bit jr, input bit j, input bit br,
                           input bit cond, input logic [31:0] rs);
        logic [31:0] nxt;
        for (int s = 0; s < stall; s++) begin
            bus.inst_ready = 1'b0;
            bus.imem_ack   = 1'($urandom);
            bus.imem_rdata = $urandom;
            rand_ctl();
            #1;
            chk("s_valid", 32'(bus.inst_valid), 32'd1);
            chk("s_inst", bus.inst, m_inst);
            chk("s_pc", bus.pc, m_pc);
            chk("s_req", 32'(bus.imem_req), 32'd0);
            @(negedge clk);
        end
        bus.inst_ready = 1'b1;
        bus.imem_ack = 1'b0;
        bus.JumpReg = jr; bus.Jump = j; bus.Branch = br; bus.br_cond = cond;
        bus.rs_data = rs;
        nxt = model_next(jr, j, br, cond, rs);
        @(negedge clk);
        bus.inst_ready = 1'b0;
        rand_ctl();
        if (nxt[1:0] != 2'b00) begin
            #1;
            chk("flt_fault", 32'(bus.fault), 32'd1);
            chk("flt_valid", 32'(bus.inst_valid), 32'd0);
            chk("flt_req", 32'(bus.imem_req), 32'd0);
            chk("flt_pc", bus.pc, m_pc);
            chk("flt_retired", bus.retired, m_ret);
        end else begin
            m_pc  = nxt;
            m_ret = m_ret + 32'd1;
            #1 chk("ret_count", bus.retired, m_ret);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
        bus.Branch = 1'b0; bus.Jump = 1'b0; bus.JumpReg = 1'b0;
        bus.br_cond = 1'b0; bus.rs_data = 32'h0;
        m_pc = 32'h0; m_inst = 32'h0; m_ret = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Zero-wait stream of addi
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 32'h2008_0005);
            chk("addi_opcode", 32'(bus.opcode), 32'h08);
            do_hold(0, 0, 0, 0, 0, 32'h0);
        end
        chk("three_retired", bus.retired, 32'd3);
        chk("next_addr_c", bus.imem_addr, 32'hC);

        // Two wait states, five-cycle downstream stall
        do_reset();
        do_fetch(2, 32'h0123_4567);
        do_hold(5, 0, 0, 0, 0, 32'h0);

        // BEQ backwards to itself, then not taken
        do_fetch(0, $urandom);
        do_hold(0, 1, 0, 0, 0, 32'h10);
        do_fetch(0, 32'h1000_FFFF);
        do_hold(1, 0, 0, 1, 1, 32'h0);
        chk("beq_taken", m_pc, 32'h10);
        do_fetch(0, 32'h1000_FFFF);
        do_hold(0, 0, 0, 1, 0, 32'h0);
        chk("beq_not_taken", m_pc, 32'h14);

        // J inside a 256MB region, then JR
        do_fetch(0, $urandom);
        do_hold(0, 1, 0, 0, 0, 32'h1000_0000);
        do_fetch(1, 32'h0800_0040);
        do_hold(0, 0, 1, 0, 0, 32'h0);
        do_fetch(0, $urandom);
        chk("j_target", bus.pc, 32'h1000_0100);
        do_hold(0, 1, 0, 0, 0, 32'h200);
        do_fetch(0, $urandom);
        chk("jr_target", bus.pc, 32'h200);

        // PC wrap at the top of the address space
        do_hold(0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        do_fetch(0, $urandom);
        do_hold(0, 0, 0, 0, 0, 32'h0);
        do_fetch(0, $urandom);
        chk("pc_wrap", bus.pc, 32'h0);
        do_hold(0, 0, 0, 0, 0, 32'h0);

        // Randomized instruction stream with aligned redirects
        for (int n = 0; n < 30; n++) begin
            do_fetch(int'($urandom_range(0, 3)), $urandom);
            do_hold(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        // Misaligned JR target -> sticky fault, cleared only by rst
        do_fetch(0, $urandom);
        do_hold(0, 1, 0, 0, 0, 32'h202);
        for (int c = 0; c < 4; c++) begin
            bus.imem_ack = 1'($urandom);
            bus.inst_ready = 1'($urandom);
            @(negedge clk);
            #1;
            chk("fault_sticky", 32'(bus.fault), 32'd1);
            chk("fault_noreq", 32'(bus.imem_req), 32'd0);
            chk("fault_novalid", 32'(bus.inst_valid), 32'd0);
            chk("fault_pc", bus.pc, m_pc);
        end
        bus.inst_ready = 1'b0;
        do_reset();

        // Reset during a wait-state fetch at 0x40 drops the late ack
        do_fetch(0, $urandom);
        do_hold(0, 1, 0, 0, 0, 32'h40);
        bus.imem_ack = 1'b0;
        #1 chk("mid_addr", bus.imem_addr, 32'h40);
        @(negedge clk);
        bus.imem_rdata = 32'hDEAD_BEEF;
        do_reset();
        do_fetch(0, 32'h2008_0005);
        do_hold(0, 0, 0, 0, 0, 32'h0);
        chk("post_rst_pc", bus.imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
